// File: rtl/serial_subtractor8_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor8_if
// Brief    : Request/result bundle for the bit-serial subtractor.
// Revision : 1.0  initial release
// ============================================================================
interface serial_subtractor8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] a;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             underflow;
    logic             range_err;

    modport master (
        output start, sum, a,
        input  busy, done, diff, underflow, range_err
    );

    modport slave (
        input  start, sum, a,
        output busy, done, diff, underflow, range_err
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor8.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor8
// Brief    : LSB-first serial subtractor recovering b = sum - a from an adder.
// Revision : 1.0  initial release
// ============================================================================
module serial_subtractor8 #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    serial_subtractor8_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_min;
    logic [WIDTH:0]   r_sub;
    logic [WIDTH:0]   r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_underflow;
    logic             r_range_err;

    logic             w_d;
    logic             w_borrow_next;
    logic [WIDTH:0]   w_res_next;

    assign w_d           = r_min[0] ^ r_sub[0] ^ r_borrow;
    assign w_borrow_next = (~r_min[0] & r_sub[0]) | (~(r_min[0] ^ r_sub[0]) & r_borrow);
    // The last bit is folded in here so results land on the final shift edge.
    assign w_res_next    = {w_d, r_res[WIDTH:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_min       <= '0;
            r_sub       <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_diff      <= '0;
            r_underflow <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    r_res    <= w_res_next;
                    r_min    <= r_min >> 1;
                    r_sub    <= r_sub >> 1;
                    r_borrow <= w_borrow_next;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH)) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_diff      <= w_res_next[WIDTH-1:0];
                        r_underflow <= w_borrow_next;
                        r_range_err <= ~w_borrow_next & w_res_next[WIDTH];
                    end
                end
                default: begin
                    // IDLE and DONE both accept a request, giving gap-free back-to-back use.
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state  <= ST_SHIFT;
                        r_busy   <= 1'b1;
                        r_min    <= bus.sum;
                        r_sub    <= {1'b0, bus.a};
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.diff      = r_diff;
    assign bus.underflow = r_underflow;
    assign bus.range_err = r_range_err;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor8.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor8
// Brief    : Directed self-checking bench for serial_subtractor8.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor8;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    serial_subtractor8_if #(.WIDTH(8)) bus ();

    serial_subtractor8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic [8:0] s, input logic [7:0] av);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sum   = s;
        bus.a     = av;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns edges from the accepting edge to done, and cycles busy was seen high.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.sum = '0;
        bus.a = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({bus.busy, bus.done, bus.diff, bus.underflow, bus.range_err} !== 11'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%0d uf=%b re=%b, want all 0",
                     bus.busy, bus.done, bus.diff, bus.underflow, bus.range_err);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input string nm, input logic [8:0] s, input logic [7:0] av,
                           input logic [7:0] ediff, input logic euf, input logic ere);
        int cyc, bc;
        start_op(s, av);
        wait_done(cyc, bc);
        n_total++;
        if (cyc !== 9) $display("FAIL %s_latency: got %0d cycles, want 9", nm, cyc);
        else n_pass++;
        n_total++;
        if ({bus.diff, bus.underflow, bus.range_err} !== {ediff, euf, ere})
            $display("FAIL %s_result: got diff=%0d uf=%b re=%b, want diff=%0d uf=%b re=%b",
                     nm, bus.diff, bus.underflow, bus.range_err, ediff, euf, ere);
        else n_pass++;
    endtask

    task automatic test_basic;
        int cyc, bc;
        start_op(9'd11, 8'd1);
        n_total++;
        if (bus.busy !== 1'b1) $display("FAIL basic_busy_rise: got %b, want 1", bus.busy);
        else n_pass++;
        wait_done(cyc, bc);
        n_total++;
        if (cyc !== 9) $display("FAIL basic_latency: got %0d, want 9", cyc);
        else n_pass++;
        n_total++;
        if (bc !== 9) $display("FAIL basic_busy_cycles: got %0d, want 9", bc);
        else n_pass++;
        n_total++;
        if ({bus.busy, bus.diff, bus.underflow, bus.range_err} !== {1'b0, 8'd10, 1'b0, 1'b0})
            $display("FAIL basic_result: got busy=%b diff=%0d uf=%b re=%b, want busy=0 diff=10 uf=0 re=0",
                     bus.busy, bus.diff, bus.underflow, bus.range_err);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if ({bus.done, bus.diff} !== {1'b0, 8'd10})
            $display("FAIL basic_done_pulse: got done=%b diff=%0d, want done=0 diff=10", bus.done, bus.diff);
        else n_pass++;
    endtask

    task automatic test_values;
        run_vec("max",   9'd510, 8'd255, 8'd255, 1'b0, 1'b0);
        run_vec("mid",   9'd165, 8'd99,  8'd66,  1'b0, 1'b0);
        run_vec("under", 9'd3,   8'd5,   8'd254, 1'b1, 1'b0);
        run_vec("range", 9'd400, 8'd10,  8'd134, 1'b0, 1'b1);
        run_vec("zero",  9'd0,   8'd0,   8'd0,   1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int cyc, bc;
        start_op(9'd11, 8'd1);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.sum   = 9'd99;
        bus.a     = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.sum   = 9'd300;
        bus.a     = 8'd200;
        wait_done(cyc, bc);
        n_total++;
        if ({bus.done, bus.diff, bus.underflow, bus.range_err} !== {1'b1, 8'd10, 1'b0, 1'b0})
            $display("FAIL ignore_busy_start: got done=%b diff=%0d uf=%b re=%b, want done=1 diff=10",
                     bus.done, bus.diff, bus.underflow, bus.range_err);
        else n_pass++;
        bus.start = 1'b1;
        bus.sum   = 9'd165;
        bus.a     = 8'd99;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_total++;
        if ({bus.busy, bus.done, bus.diff} !== {1'b1, 1'b0, 8'd10})
            $display("FAIL b2b_accept: got busy=%b done=%b diff=%0d, want busy=1 done=0 diff=10",
                     bus.busy, bus.done, bus.diff);
        else n_pass++;
        wait_done(cyc, bc);
        n_total++;
        if (cyc !== 9 || bus.diff !== 8'd66)
            $display("FAIL b2b_result: got cycles=%0d diff=%0d, want cycles=9 diff=66", cyc, bus.diff);
        else n_pass++;
    endtask

    task automatic test_reset_abort;
        int cyc, bc;
        bit seen;
        start_op(9'd11, 8'd1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.busy, bus.done, bus.diff, bus.underflow, bus.range_err} !== 11'd0)
            $display("FAIL abort_async: got busy=%b done=%b diff=%0d uf=%b re=%b, want all 0",
                     bus.busy, bus.done, bus.diff, bus.underflow, bus.range_err);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL abort_no_done: got activity=%b, want 0", seen);
        else n_pass++;
        start_op(9'd11, 8'd1);
        wait_done(cyc, bc);
        n_total++;
        if (cyc !== 9 || bus.diff !== 8'd10)
            $display("FAIL abort_recover: got cycles=%0d diff=%0d, want cycles=9 diff=10", cyc, bus.diff);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset;
        test_basic;
        test_values;
        test_back_to_back;
        test_reset_abort;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
